// File: rtl/axi4_s_write_responder_if.sv
// AXI4 write-channel bundle (AW/W/B) between a write manager and a subordinate.
`timescale 1ns/1ps
interface axi4_s_write_responder_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
);
  // Write address channel
  logic [ADDRESS_SIZE-1:0] s_axi_awaddr;
  logic [7:0]              s_axi_awlen;
  logic [2:0]              s_axi_awsize;
  logic [1:0]              s_axi_awburst;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  // Write data channel
  logic [DATA_SIZE-1:0]    s_axi_wdata;
  logic [DATA_SIZE/8-1:0]  s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  // Write response channel
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;

  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready
  );
endinterface

// File: rtl/axi4_s_write_responder.sv
// AXI4 write subordinate: accepts one burst at a time, byte-merges each beat
// into a DEPTH-word register bank and returns a single B response.
// The bank is readable combinationally through the debug port.
`timescale 1ns/1ps
module axi4_s_write_responder #(
  parameter int                    ADDRESS_SIZE = 32,
  parameter int                    DATA_SIZE    = 32,
  parameter int                    DEPTH        = 16,
  parameter logic [ADDRESS_SIZE-1:0] BASE_ADDR  = '0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  axi4_s_write_responder_if.slave    bus,
  input  logic [$clog2(DEPTH)-1:0]   dbg_index,
  output logic [DATA_SIZE-1:0]       dbg_data
);

  localparam int STRB_W    = DATA_SIZE / 8;
  localparam int SIZE_LOG2 = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(DEPTH);

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StResp = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [1:0]              burst_q, burst_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d;
  // AW-check result alone: suppresses every bank write of the burst.
  logic                    aw_err_q, aw_err_d;

  logic [DATA_SIZE-1:0]    bank_q [DEPTH];

  logic                    aw_hs, w_hs, b_hs;
  logic [ADDRESS_SIZE-1:0] size_mask;
  logic                    aw_check_err;
  logic [ADDRESS_SIZE-1:0] offset;
  logic [ADDRESS_SIZE-1:0] word_off;
  logic                    in_range;
  logic [IDX_W-1:0]        beat_idx;
  logic                    len_hit;
  logic                    final_beat;
  logic                    beat_err;
  logic                    bank_we;
  logic [DATA_SIZE-1:0]    strb_mask;

  assign bus.s_axi_awready = awready_q;
  assign bus.s_axi_wready  = wready_q;
  assign bus.s_axi_bvalid  = bvalid_q;
  assign bus.s_axi_bresp   = bresp_q;

  assign aw_hs = awready_q & bus.s_axi_awvalid;
  assign w_hs  = wready_q  & bus.s_axi_wvalid;
  assign b_hs  = bvalid_q  & bus.s_axi_bready;

  // Only full-width beats, FIXED/INCR bursts and size-aligned starts are served.
  assign size_mask    = (ADDRESS_SIZE'(1) << bus.s_axi_awsize) - ADDRESS_SIZE'(1);
  assign aw_check_err = (bus.s_axi_awsize != 3'(SIZE_LOG2))
                      | bus.s_axi_awburst[1]
                      | ((bus.s_axi_awaddr & size_mask) != '0);

  // Addresses below BASE_ADDR underflow to huge offsets, so a single
  // unsigned compare rejects both sides; the bank index never wraps.
  assign offset   = addr_q - BASE_ADDR;
  assign word_off = offset >> SIZE_LOG2;
  assign in_range = (word_off < ADDRESS_SIZE'(DEPTH));
  assign beat_idx = word_off[IDX_W-1:0];

  // The burst closes on wlast or on the awlen-th beat; disagreement is an error.
  assign len_hit    = (beat_cnt_q == len_q);
  assign final_beat = bus.s_axi_wlast | len_hit;
  assign beat_err   = ~in_range | (bus.s_axi_wlast != len_hit);

  assign bank_we = w_hs & in_range & ~aw_err_q;

  // Expand byte strobes into a bit mask for the read-modify-write merge.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb_mask
      assign strb_mask[gi*8 +: 8] = {8{bus.s_axi_wstrb[gi]}};
    end
  endgenerate

  // State and registered-output update.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      addr_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      aw_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      aw_err_q   <= aw_err_d;
    end
  end

  // Next-state and next-output decode for the three-state burst FSM.
  always_comb begin
    state_d    = state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    aw_err_d   = aw_err_q;

    case (state_q)
      StIdle: begin
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        if (aw_hs) begin
          addr_d     = bus.s_axi_awaddr;
          len_d      = bus.s_axi_awlen;
          burst_d    = bus.s_axi_awburst;
          beat_cnt_d = '0;
          err_d      = aw_check_err;
          aw_err_d   = aw_check_err;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          state_d    = StData;
        end
      end

      StData: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          err_d      = err_q | beat_err;
          if (burst_q == BURST_INCR) begin
            addr_d = addr_q + ADDRESS_SIZE'(STRB_W);
          end
          if (final_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (err_q | beat_err) ? RESP_SLV : RESP_OKAY;
            state_d  = StResp;
          end
        end
      end

      StResp: begin
        if (b_hs) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
      end
    endcase
  end

  // Register bank: cleared on reset, byte-merged on each accepted in-range beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (bank_we) begin
      bank_q[beat_idx] <= (bank_q[beat_idx] & ~strb_mask)
                        | (bus.s_axi_wdata & strb_mask);
    end
  end

  assign dbg_data = bank_q[dbg_index];

endmodule

// File: tb/tb_axi4_s_write_responder.sv
// Self-checking bench for axi4_s_write_responder: a reference model tracks the
// bank and expected B responses; responses are queued and popped on B handshakes.
`timescale 1ns/1ps
module tb_axi4_s_write_responder;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LIMIT = 50;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  dbg_index;
  logic [31:0] dbg_data;

  axi4_s_write_responder_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  axi4_s_write_responder #(
    .ADDRESS_SIZE(AW),
    .DATA_SIZE   (DW),
    .DEPTH       (DEPTH),
    .BASE_ADDR   (32'h0)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .bus      (bus),
    .dbg_index(dbg_index),
    .dbg_data (dbg_data)
  );

  always #5 aclk = ~aclk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [DEPTH];
  logic [1:0]  exp_q [$];
  logic [1:0]  exp_b;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic abort(input string tag);
    check(tag, 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Handshake seen on a falling edge completes on the following rising edge.
  always @(negedge aclk) begin
    if (aresetn && bus.s_axi_bvalid && bus.s_axi_bready) begin
      if (exp_q.size() == 0) begin
        check("b_unexpected", 32'd1, 32'd0);
      end else begin
        exp_b = exp_q.pop_front();
        check("bresp", {30'd0, bus.s_axi_bresp}, {30'd0, exp_b});
      end
    end
  end

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    bus.s_axi_awaddr  = addr;
    bus.s_axi_awlen   = len;
    bus.s_axi_awsize  = size;
    bus.s_axi_awburst = burst;
    bus.s_axi_awvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_awready && n < LIMIT) begin tick(); n++; end
    if (!bus.s_axi_awready) abort("aw_timeout");
    tick();
    bus.s_axi_awvalid = 1'b0;
    check("wready_after_aw", {31'd0, bus.s_axi_wready}, 32'd1);
    check("awready_busy", {31'd0, bus.s_axi_awready}, 32'd0);
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input bit last);
    int n;
    bus.s_axi_wdata  = data;
    bus.s_axi_wstrb  = strb;
    bus.s_axi_wlast  = last;
    bus.s_axi_wvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_wready && n < LIMIT) begin tick(); n++; end
    if (!bus.s_axi_wready) abort("w_timeout");
    tick();
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
  endtask

  task automatic dump_bank(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      dbg_index = 4'(i);
      #1;
      check($sformatf("%s_bank[%0d]", tag, i), dbg_data, model[i]);
    end
    tick();
  endtask

  // One complete burst: AW, beats until the model says the burst closes, then B.
  task automatic xfer(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                      input logic [1:0] burst, input int last_beat, input bit gaps,
                      input int hold_b);
    bit          aw_err, err, wl, lh;
    logic [31:0] a, idx;
    logic [1:0]  e;
    int          n;
    aw_err = (size != 3'd2) || burst[1] || ((addr & ((32'd1 << size) - 32'd1)) != 32'd0);
    err    = aw_err;
    a      = addr;
    send_aw(addr, len, size, burst);
    for (int b = 0; b < 16; b++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      idx = a >> 2;
      wl  = (b == last_beat);
      lh  = (b == int'(len));
      if (idx < 32'(DEPTH)) dbg_index = idx[3:0];
      send_beat(wd[b], ws[b], wl);
      if (idx < 32'(DEPTH)) begin
        if (!aw_err) begin
          for (int k = 0; k < 4; k++)
            if (ws[b][k]) model[idx][k*8 +: 8] = wd[b][k*8 +: 8];
        end
        check("beat_visible", dbg_data, model[idx]);
      end else begin
        err = 1'b1;
      end
      if (wl != lh) err = 1'b1;
      if (burst == 2'b01) a = a + 32'd4;
      if (wl || lh) break;
    end
    e = err ? 2'b10 : 2'b00;
    check("bvalid_after_last", {31'd0, bus.s_axi_bvalid}, 32'd1);
    check("wready_after_last", {31'd0, bus.s_axi_wready}, 32'd0);
    exp_q.push_back(e);
    for (int h = 0; h < hold_b; h++) begin
      tick();
      check("hold_bvalid", {31'd0, bus.s_axi_bvalid}, 32'd1);
      check("hold_bresp", {30'd0, bus.s_axi_bresp}, {30'd0, e});
      check("hold_awready", {31'd0, bus.s_axi_awready}, 32'd0);
    end
    bus.s_axi_bready = 1'b1;
    n = 0;
    while (!bus.s_axi_bvalid && n < LIMIT) begin tick(); n++; end
    if (!bus.s_axi_bvalid) abort("b_timeout");
    tick();
    bus.s_axi_bready = 1'b0;
    check("bvalid_clear", {31'd0, bus.s_axi_bvalid}, 32'd0);
    check("awready_after_b", {31'd0, bus.s_axi_awready}, 32'd1);
    $display("xfer addr=%h len=%0d size=%0d burst=%0d expected_bresp=%0d", addr, len, size, burst, e);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_awready"}, {31'd0, bus.s_axi_awready}, 32'd0);
    check({tag, "_wready"},  {31'd0, bus.s_axi_wready},  32'd0);
    check({tag, "_bvalid"},  {31'd0, bus.s_axi_bvalid},  32'd0);
    check({tag, "_bresp"},   {30'd0, bus.s_axi_bresp},   32'd0);
  endtask

  initial begin
    #200000;
    abort("watchdog");
  end

  initial begin
    bus.s_axi_awaddr  = '0;
    bus.s_axi_awlen   = '0;
    bus.s_axi_awsize  = '0;
    bus.s_axi_awburst = '0;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata   = '0;
    bus.s_axi_wstrb   = '0;
    bus.s_axi_wlast   = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready  = 1'b0;
    dbg_index         = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset state
    aresetn = 1'b0;
    repeat (3) tick();
    reset_outputs("reset");
    dump_bank("reset");
    aresetn = 1'b1;
    tick();
    check("awready_after_release", {31'd0, bus.s_axi_awready}, 32'd1);

    // W presented before any AW is not accepted
    bus.s_axi_wvalid = 1'b1;
    repeat (3) begin
      tick();
      check("wready_idle", {31'd0, bus.s_axi_wready}, 32'd0);
    end
    bus.s_axi_wvalid = 1'b0;

    // 1: single write
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    xfer(32'h8, 8'd0, 3'd2, 2'b01, 0, 1'b0, 0);
    dbg_index = 4'd2; #1;
    check("t1_bank2", dbg_data, 32'hDEADBEEF);

    // 2: INCR burst of four
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    xfer(32'h0, 8'd3, 3'd2, 2'b01, 3, 1'b0, 0);
    dump_bank("t2");

    // 3: strobe merge
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    xfer(32'h14, 8'd0, 3'd2, 2'b01, 0, 1'b0, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    xfer(32'h14, 8'd0, 3'd2, 2'b01, 0, 1'b0, 0);
    dbg_index = 4'd5; #1;
    check("t3_bank5", dbg_data, 32'h11BB33DD);

    // 4: boundary and error cases
    wd[0] = 32'hA0A0A0A0; wd[1] = 32'hB1B1B1B1; ws[0] = 4'hF; ws[1] = 4'hF;
    xfer(32'h3C, 8'd1, 3'd2, 2'b00, 1, 1'b0, 0);
    dbg_index = 4'd15; #1;
    check("t4_fixed_bank15", dbg_data, 32'hB1B1B1B1);
    wd[0] = 32'hC2C2C2C2; wd[1] = 32'hD3D3D3D3;
    xfer(32'h3C, 8'd1, 3'd2, 2'b01, 1, 1'b0, 0);
    wd[0] = 32'hE4E4E4E4;
    xfer(32'h20, 8'd0, 3'd1, 2'b01, 0, 1'b0, 0);
    wd[0] = 32'hF5F5F5F5; wd[1] = 32'h06060606;
    xfer(32'h20, 8'd1, 3'd2, 2'b10, 1, 1'b0, 0);
    wd[0] = 32'h17171717;
    xfer(32'h21, 8'd0, 3'd2, 2'b01, 0, 1'b0, 0);
    wd[0] = 32'h28282828; wd[1] = 32'h39393939;
    xfer(32'h24, 8'd3, 3'd2, 2'b01, 1, 1'b0, 0);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'h0;
    xfer(32'h30, 8'd0, 3'd2, 2'b01, 0, 1'b0, 0);
    dump_bank("t4");

    // 5: backpressure on B and random gaps on W
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
    xfer(32'h18, 8'd2, 3'd2, 2'b01, 2, 1'b0, 5);
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    xfer(32'h20, 8'd7, 3'd2, 2'b01, 7, 1'b1, 2);
    dump_bank("t5");

    // 6: reset in the middle of a burst
    send_aw(32'h0, 8'd3, 3'd2, 2'b01);
    send_beat(32'h12345678, 4'hF, 1'b0);
    send_beat(32'h9ABCDEF0, 4'hF, 1'b0);
    aresetn = 1'b0;
    tick();
    reset_outputs("midreset");
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    dump_bank("midreset");
    aresetn = 1'b1;
    tick();
    $display("xfer addr=00000000 len=3 abandoned by reset");
    wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
    xfer(32'h4, 8'd0, 3'd2, 2'b01, 0, 1'b0, 0);
    dump_bank("t6");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
